// File: rtl/prio_dec_pkg.sv
// Shared definitions for the registered priority-code decoder.
//   state_e    : FSM states (IDLE, DRIVE, GAP)
//   CODE_W_DEF : default input code width
//   STATS_W    : width of the optional decode counter
//   out_w()    : number of one-hot output lines for a code width
//   cnt_w()    : counter width able to hold a given maximum value
// Optional feature macro used by the other files: PRIO_DEC_STATS_EN.
package prio_dec_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_e;

    localparam int unsigned CODE_W_DEF = 2;
    localparam int unsigned STATS_W    = 16;

    // Code 0 means "no line", so a CODE_W-bit code selects 2**CODE_W - 1 lines.
    function automatic int unsigned out_w(int unsigned code_w);
        return (32'd1 << code_w) - 32'd1;
    endfunction

    function automatic int unsigned cnt_w(int unsigned max_val);
        return (max_val <= 32'd1) ? 32'd1 : $clog2(max_val + 32'd1);
    endfunction

endpackage

// File: rtl/priority_decoder_seq_if.sv
// Code-in / select-out bundle of priority_decoder_seq.
//   code_valid_i, code_i : code offered by the producer
//   code_ready_o         : decoder can accept a code this cycle
//   data_out_o           : one-hot decoded select lines
//   busy_o, done_o       : decoder status
//   dec_count_o          : decoded nonzero code count (PRIO_DEC_STATS_EN only)
// Modports: master = code producer / observer, slave = decoder.
interface priority_decoder_seq_if #(
    parameter int unsigned CODE_W = prio_dec_pkg::CODE_W_DEF
);
    import prio_dec_pkg::*;

    localparam int unsigned OUT_W = out_w(CODE_W);

    logic              code_valid_i;
    logic [CODE_W-1:0] code_i;
    logic              code_ready_o;
    logic [OUT_W-1:0]  data_out_o;
    logic              busy_o;
    logic              done_o;
`ifdef PRIO_DEC_STATS_EN
    logic [STATS_W-1:0] dec_count_o;

    modport master (
        output code_valid_i, code_i,
        input  code_ready_o, data_out_o, busy_o, done_o, dec_count_o
    );
    modport slave (
        input  code_valid_i, code_i,
        output code_ready_o, data_out_o, busy_o, done_o, dec_count_o
    );
`else
    modport master (
        output code_valid_i, code_i,
        input  code_ready_o, data_out_o, busy_o, done_o
    );
    modport slave (
        input  code_valid_i, code_i,
        output code_ready_o, data_out_o, busy_o, done_o
    );
`endif

endinterface

// File: rtl/prio_dec_hold_cnt.sv
// Loadable down-counter with a zero flag; times both the hold and gap windows.
//   clk_i, rst_n_i : clock, async active-low reset (count cleared to 0)
//   load_i         : load load_val_i (wins over dec_i)
//   load_val_i     : value to load
//   dec_i          : decrement; holds at zero
//   zero_o         : count is zero
module prio_dec_hold_cnt #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/priority_decoder_seq.sv
// Registered priority-code decoder: accepts a code over valid/ready, drives the
// matching one-hot select line for HOLD_CYCLES cycles, then idles GAP_CYCLES
// cycles before accepting again. Code 0 only produces a done pulse.
//   clk_i, rst_n_i : clock, async active-low reset
//   bus (slave)    : code_valid_i, code_i, code_ready_o, data_out_o, busy_o,
//                    done_o, dec_count_o
// Optional feature: define PRIO_DEC_STATS_EN to add dec_count_o, a saturating
// count of accepted nonzero codes.
module priority_decoder_seq
    import prio_dec_pkg::*;
#(
    parameter int unsigned CODE_W      = CODE_W_DEF,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    priority_decoder_seq_if.slave  bus
);

    localparam int unsigned OUT_W  = out_w(CODE_W);
    localparam int unsigned CntMax =
        ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) - 1;
    localparam int unsigned CNT_W  = cnt_w(CntMax);
    localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GapLoad  =
        (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic             accept, code_nz;

    // ready_q is only ever set while in IDLE, so accept implies IDLE.
    assign accept  = bus.code_valid_i & ready_q;
    assign code_nz = |bus.code_i;

    prio_dec_hold_cnt #(
        .WIDTH (CNT_W)
    ) u_hold_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Next state and window counter control.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = HoldLoad;
        cnt_dec      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && code_nz) begin
                    state_d  = DRIVE;
                    cnt_load = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_zero) begin
                    if (GAP_CYCLES > 0) begin
                        state_d      = GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = GapLoad;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs: next values of select lines, done pulse and ready.
    always_comb begin
        data_d  = '0;
        done_d  = 1'b0;
        ready_d = (state_d == IDLE);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    done_d = !code_nz;
                    if (code_nz) begin
                        data_d = OUT_W'(1) << (bus.code_i - CODE_W'(1));
                    end
                end
            end
            DRIVE: begin
                if (cnt_zero) begin
                    done_d = 1'b1;
                end else begin
                    data_d = data_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.data_out_o   = data_q;
    assign bus.done_o       = done_q;
    assign bus.code_ready_o = ready_q;
    assign bus.busy_o       = (state_q != IDLE);

`ifdef PRIO_DEC_STATS_EN
    logic [STATS_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (accept && code_nz && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.dec_count_o = count_q;
`endif

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Self-checking bench for priority_decoder_seq: table-driven codes, hand-written
// multi-cycle sequences, and randomized traffic against a timeline model.
module tb_priority_decoder_seq;

    localparam int HA = 4;  // hold cycles of dut_a
    localparam int GA = 1;  // gap cycles of dut_a

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    priority_decoder_seq_if #(.CODE_W(2)) bus_a ();
    priority_decoder_seq_if #(.CODE_W(2)) bus_b ();

    priority_decoder_seq #(
        .CODE_W      (2),
        .HOLD_CYCLES (HA),
        .GAP_CYCLES  (GA)
    ) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_a)
    );

    priority_decoder_seq #(
        .CODE_W      (2),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (0)
    ) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready_a();
        int n = 0;
        while (bus_a.code_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready_a", {31'd0, bus_a.code_ready_o}, 32'd1);
    endtask

    // One code through dut_a, checking the full hold/gap timeline.
    task automatic run_vec(input logic [1:0] code, input logic [2:0] exp_data);
        wait_ready_a();
        bus_a.code_valid_i = 1'b1;
        bus_a.code_i       = code;
        @(negedge clk);
        bus_a.code_valid_i = 1'b0;
        bus_a.code_i       = ~code;
        if (code == 2'd0) begin
            check("zero_data", {29'd0, bus_a.data_out_o}, 32'd0);
            check("zero_done", {31'd0, bus_a.done_o}, 32'd1);
            check("zero_ready", {31'd0, bus_a.code_ready_o}, 32'd1);
            check("zero_busy", {31'd0, bus_a.busy_o}, 32'd0);
            @(negedge clk);
            check("zero_done_end", {31'd0, bus_a.done_o}, 32'd0);
        end else begin
            for (int i = 0; i < HA; i++) begin
                check("hold_data", {29'd0, bus_a.data_out_o}, {29'd0, exp_data});
                check("hold_done", {31'd0, bus_a.done_o}, 32'd0);
                check("hold_ready", {31'd0, bus_a.code_ready_o}, 32'd0);
                @(negedge clk);
            end
            check("rel_data", {29'd0, bus_a.data_out_o}, 32'd0);
            check("rel_done", {31'd0, bus_a.done_o}, 32'd1);
            check("gap_busy", {31'd0, bus_a.busy_o}, 32'd1);
            check("gap_ready", {31'd0, bus_a.code_ready_o}, 32'd0);
            @(negedge clk);
            check("idle_ready", {31'd0, bus_a.code_ready_o}, 32'd1);
            check("idle_busy", {31'd0, bus_a.busy_o}, 32'd0);
            check("idle_done", {31'd0, bus_a.done_o}, 32'd0);
        end
    endtask

    typedef struct {
        logic [1:0] code;
        logic [2:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int         low;
        int         cyc, ready_at, acc, line, nz;
        bit         done_at[int];
        logic [2:0] ed;
        logic       v;
        logic [1:0] c;

        checks   = 0;
        failures = 0;
        vecs[0]  = '{code: 2'd1, exp_data: 3'b001};
        vecs[1]  = '{code: 2'd2, exp_data: 3'b010};
        vecs[2]  = '{code: 2'd3, exp_data: 3'b100};
        vecs[3]  = '{code: 2'd0, exp_data: 3'b000};
        vecs[4]  = '{code: 2'd2, exp_data: 3'b010};

        rst_n = 1'b0;
        bus_a.code_valid_i = 1'b0;
        bus_a.code_i       = 2'd0;
        bus_b.code_valid_i = 1'b0;
        bus_b.code_i       = 2'd0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_data", {29'd0, bus_a.data_out_o}, 32'd0);
        check("rst_ready", {31'd0, bus_a.code_ready_o}, 32'd0);
        check("rst_busy", {31'd0, bus_a.busy_o}, 32'd0);
        check("rst_done", {31'd0, bus_a.done_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_after", {31'd0, bus_a.code_ready_o}, 32'd1);

        // Table-driven codes.
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i].code, vecs[i].exp_data);
        end

        // Valid held high; code changed while busy must not be sampled.
        wait_ready_a();
        bus_a.code_valid_i = 1'b1;
        bus_a.code_i       = 2'd1;
        @(negedge clk);
        bus_a.code_i = 2'd2;
        low = 0;
        while (bus_a.code_ready_o !== 1'b1 && low < 20) begin
            check("b2b_line", {29'd0, bus_a.data_out_o}, (low < HA) ? 32'd1 : 32'd0);
            low++;
            @(negedge clk);
        end
        check("b2b_ready_low", low, HA + GA);
        @(negedge clk);
        bus_a.code_valid_i = 1'b0;
        check("b2b_second", {29'd0, bus_a.data_out_o}, 32'b010);
        wait_ready_a();

        // HOLD=1, GAP=0 instance with valid held high.
        bus_b.code_valid_i = 1'b1;
        bus_b.code_i       = 2'd2;
        @(negedge clk);
        check("b_pulse", {29'd0, bus_b.data_out_o}, 32'b010);
        check("b_pulse_ready", {31'd0, bus_b.code_ready_o}, 32'd0);
        @(negedge clk);
        check("b_rel_data", {29'd0, bus_b.data_out_o}, 32'd0);
        check("b_rel_done", {31'd0, bus_b.done_o}, 32'd1);
        check("b_rel_ready", {31'd0, bus_b.code_ready_o}, 32'd1);
        @(negedge clk);
        bus_b.code_valid_i = 1'b0;
        check("b_reaccept", {29'd0, bus_b.data_out_o}, 32'b010);
        @(negedge clk);
        check("b_rel2_done", {31'd0, bus_b.done_o}, 32'd1);

        // Asynchronous reset in the middle of DRIVE.
        wait_ready_a();
        bus_a.code_valid_i = 1'b1;
        bus_a.code_i       = 2'd3;
        @(negedge clk);
        bus_a.code_valid_i = 1'b0;
        @(negedge clk);
        check("mid_drive", {29'd0, bus_a.data_out_o}, 32'b100);
        #2 rst_n = 1'b0;
        #1;
        check("async_data", {29'd0, bus_a.data_out_o}, 32'd0);
        check("async_busy", {31'd0, bus_a.busy_o}, 32'd0);
        check("async_ready", {31'd0, bus_a.code_ready_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, bus_a.code_ready_o}, 32'd1);
        check("post_rst_data", {29'd0, bus_a.data_out_o}, 32'd0);

        // Randomized traffic against a cycle-timeline model.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        cyc      = 0;
        ready_at = 1;
        acc      = 0;
        line     = 0;
        nz       = 0;
        for (int it = 0; it < 300; it++) begin
            ed = '0;
            if (line != 0 && cyc >= acc && cyc < acc + HA) ed = 3'(1) << (line - 1);
            check("rnd_data", {29'd0, bus_a.data_out_o}, {29'd0, ed});
            check("rnd_ready", {31'd0, bus_a.code_ready_o}, (cyc >= ready_at) ? 32'd1 : 32'd0);
            check("rnd_done", {31'd0, bus_a.done_o}, done_at.exists(cyc) ? 32'd1 : 32'd0);
            check("rnd_busy", {31'd0, bus_a.busy_o},
                  (line != 0 && cyc >= acc && cyc < acc + HA + GA) ? 32'd1 : 32'd0);
            v = 1'($urandom_range(0, 1));
            c = 2'($urandom_range(0, 3));
            bus_a.code_valid_i = v;
            bus_a.code_i       = c;
            if (v && cyc >= ready_at) begin
                if (c != 2'd0) begin
                    acc      = cyc + 1;
                    line     = int'(c);
                    ready_at = acc + HA + GA;
                    done_at[acc + HA] = 1'b1;
                    nz++;
                end else begin
                    done_at[cyc + 1] = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus_a.code_valid_i = 1'b0;

`ifdef PRIO_DEC_STATS_EN
        check("dec_count", {16'd0, bus_a.dec_count_o}, nz);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
